// File: rtl/lb_stream_sched_if.sv
// Stream / memory-core bundle for lb_stream_sched.
//   in_data, in_valid, in_ready        : pixel stream from the source
//   mem_flush, mem_wen, mem_ren,
//   mem_data                           : controls and write data to memory_core
//   mem_valid_out, mem_data_out        : read return from memory_core
//   out_data, out_valid                : registered read return to the consumer
// master: the scheduler side; slave: the surrounding environment.
interface lb_stream_sched_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_flush;
  logic              mem_wen;
  logic              mem_ren;
  logic [DATA_W-1:0] mem_data;
  logic              mem_valid_out;
  logic [DATA_W-1:0] mem_data_out;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;

  modport master (
    input  in_data, in_valid, mem_valid_out, mem_data_out,
    output in_ready, mem_flush, mem_wen, mem_ren, mem_data, out_data, out_valid
  );

  modport slave (
    output in_data, in_valid, mem_valid_out, mem_data_out,
    input  in_ready, mem_flush, mem_wen, mem_ren, mem_data, out_data, out_valid
  );
endinterface

// File: rtl/lb_stream_sched.sv
// Sequencer for one line-buffer memory_core (mode 0, chain off, tile_en=1).
// Flushes the core, fills it to the configured depth, then streams with one
// read per accepted write until cfg_iter_cnt reads are issued, and waits for
// that many core outputs before pulsing done.
// Ports:
//   clk, reset (async, active-low)
//   start        : 1-cycle run request, honoured in IDLE only
//   cfg_depth    : line depth (0 treated as 1), sampled at start
//   cfg_iter_cnt : outputs expected per run, sampled at start
//   busy, done, err : status (err is sticky until reset)
//   bus          : stream / core / output bundle (lb_stream_sched_if.master)
module lb_stream_sched #(
  parameter int DATA_W  = 16,
  parameter int DEPTH_W = 16,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [DEPTH_W-1:0] cfg_depth,
  input  logic [CNT_W-1:0]   cfg_iter_cnt,
  output logic               busy,
  output logic               done,
  output logic               err,
  lb_stream_sched_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_FILL,
    S_STREAM,
    S_WAIT,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [CNT_W-1:0]   iter_q, iter_d;
  logic [DEPTH_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic               err_q, err_d;

  logic               in_ready_c;
  logic               stream_c;
  logic               run_c;
  logic               accept;
  logic               fwd;
  logic [DEPTH_W-1:0] occ_inc;
  logic [CNT_W-1:0]   rd_inc;
  logic [CNT_W-1:0]   out_inc;

  assign accept  = bus.in_valid & in_ready_c;
  assign occ_inc = occ_q + DEPTH_W'(1);
  assign rd_inc  = rd_cnt_q + CNT_W'(1);
  assign out_inc = out_cnt_q + CNT_W'(1);
  // Core returns are only meaningful while reads can be outstanding.
  assign fwd     = bus.mem_valid_out & run_c;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_FLUSH;
      S_FLUSH:  state_d = (iter_q == '0) ? S_DONE : S_FILL;
      S_FILL:   if (accept && (occ_inc == depth_q)) state_d = S_STREAM;
      S_STREAM: if (accept && (rd_inc == iter_q)) state_d = S_WAIT;
      S_WAIT:   if (out_cnt_q == iter_q) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready_c    = 1'b0;
    stream_c      = 1'b0;
    run_c         = 1'b0;
    bus.mem_flush = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    unique case (state_q)
      S_IDLE:   busy = 1'b0;
      S_FLUSH:  bus.mem_flush = 1'b1;
      S_FILL:   in_ready_c = 1'b1;
      S_STREAM: begin
        in_ready_c = 1'b1;
        stream_c   = 1'b1;
        run_c      = 1'b1;
      end
      S_WAIT:   run_c = 1'b1;
      S_DONE:   done = 1'b1;
      default:  busy = 1'b1;
    endcase
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.mem_wen   = accept;
  assign bus.mem_ren   = accept & stream_c;
  assign bus.mem_data  = bus.in_data;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign err           = err_q;

  // Counter / datapath next-state
  always_comb begin
    depth_d     = depth_q;
    iter_d      = iter_q;
    occ_d       = occ_q;
    rd_cnt_d    = rd_cnt_q;
    out_cnt_d   = out_cnt_q;
    out_valid_d = fwd;
    out_data_d  = bus.mem_data_out;
    err_d       = err_q | (bus.mem_valid_out & ~run_c);

    if ((state_q == S_IDLE) && start) begin
      depth_d = (cfg_depth == '0) ? DEPTH_W'(1) : cfg_depth;
      iter_d  = cfg_iter_cnt;
    end
    if (state_q == S_FLUSH) begin
      occ_d     = '0;
      rd_cnt_d  = '0;
      out_cnt_d = '0;
    end
    if ((state_q == S_FILL) && accept)   occ_d    = occ_inc;
    if ((state_q == S_STREAM) && accept) rd_cnt_d = rd_inc;
    // Saturate at the target so a spurious extra return cannot wrap the count.
    if (fwd && (out_cnt_q != iter_q))    out_cnt_d = out_inc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      depth_q     <= '0;
      iter_q      <= '0;
      occ_q       <= '0;
      rd_cnt_q    <= '0;
      out_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      depth_q     <= depth_d;
      iter_q      <= iter_d;
      occ_q       <= occ_d;
      rd_cnt_q    <= rd_cnt_d;
      out_cnt_q   <= out_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_lb_stream_sched.sv
module tb_lb_stream_sched;
  localparam int DW  = 16;
  localparam int DPW = 16;
  localparam int CW  = 32;
  localparam int BUDGET = 400;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic [DPW-1:0] cfg_depth = '0;
  logic [CW-1:0]  cfg_iter = '0;
  logic           busy, done, err;

  lb_stream_sched_if #(.DATA_W(DW)) bus ();

  lb_stream_sched #(.DATA_W(DW), .DEPTH_W(DPW), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .cfg_depth    (cfg_depth),
    .cfg_iter_cnt (cfg_iter),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Line-buffer core model: FIFO order, read latency 1, read before write.
  logic [DW-1:0] core_q[$];
  logic          inject = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.mem_valid_out <= 1'b0;
      bus.mem_data_out  <= '0;
      core_q.delete();
    end else begin
      if (bus.mem_flush) core_q.delete();
      bus.mem_valid_out <= bus.mem_ren | inject;
      if (inject) bus.mem_data_out <= 16'hDEAD;
      else if (bus.mem_ren && core_q.size() > 0) bus.mem_data_out <= core_q.pop_front();
      if (bus.mem_wen) core_q.push_back(bus.mem_data);
    end
  end

  // Scoreboard and per-run statistics, sampled 1 time unit before each rising edge.
  logic [DW-1:0] exp_q[$];
  int  cyc = 0, last_out = 0, run_iter = 0;
  int  flush_c = 0, wen_c = 0, wenonly_c = 0, ren_c = 0, outv_c = 0, done_c = 0;
  bit  last_acc = 0;

  always @(negedge clk) begin
    #4;
    cyc++;
    last_acc = bus.in_valid && bus.in_ready;
    if (bus.mem_flush) flush_c++;
    if (bus.mem_wen) begin
      wen_c++;
      if (!bus.mem_ren) wenonly_c++;
    end
    if (bus.mem_ren) begin
      ren_c++;
      check_eq("ren_without_wen", bus.mem_wen, 1'b1);
    end
    if (bus.in_valid) check_eq("mem_data_pass", bus.mem_data, bus.in_data);
    else              check_eq("wen_no_valid", bus.mem_wen, 1'b0);
    if (bus.out_valid) begin
      outv_c++;
      last_out = cyc;
      if (exp_q.size() > 0) check_eq("out_data", bus.out_data, exp_q.pop_front());
      else                  check_eq("out_unexpected", 1'b1, 1'b0);
    end
    if (done) begin
      done_c++;
      if (run_iter > 0) check_eq("done_latency", cyc - last_out, 1);
    end
  end

  int base = 16'h1000;

  // mode 0: normal run; 1: inject stray core output in FILL and a start in STREAM;
  // 2: drop reset after two reads in STREAM.
  task automatic run(input int d, input int it, input bit toggle, input int mode, input bit exp_err);
    int k = 0, pidx = 0, budget = 0, eff;
    bit v = 1'b1, injd = 1'b0, std = 1'b0, errchk = 1'b0;
    eff = (d == 0) ? 1 : d;
    flush_c = 0; wen_c = 0; wenonly_c = 0; ren_c = 0; outv_c = 0; done_c = 0;
    exp_q.delete();
    run_iter = it;
    last_out = cyc;
    base += 16'h100;
    @(negedge clk);
    cfg_depth = DPW'(d);
    cfg_iter  = CW'(it);
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_after_start", busy, 1'b1);
    while (done_c == 0 && budget < BUDGET) begin
      if (last_acc) k++;
      start  = 1'b0;
      inject = 1'b0;
      v = toggle ? ~v : 1'b1;
      bus.in_valid = v;
      if (v) begin
        bus.in_data = 16'(base + k);
        if (k == pidx) begin
          if (k < it) exp_q.push_back(16'(base + k));
          pidx++;
        end
      end else begin
        bus.in_data = 16'($urandom);
      end
      if (mode == 1 && !injd && wen_c == 2) begin
        inject = 1'b1;
        injd   = 1'b1;
      end
      if (mode == 1 && injd && !errchk && wen_c >= 5) begin
        check_eq("err_set_in_fill", err, 1'b1);
        check_eq("no_out_in_fill", outv_c, 0);
        errchk = 1'b1;
      end
      if (mode == 1 && !std && ren_c == 1) begin
        start = 1'b1;
        std   = 1'b1;
      end
      if (mode == 2 && ren_c == 2) begin
        reset = 1'b0;
        #1;
        check_eq("abort_busy", busy, 1'b0);
        check_eq("abort_in_ready", bus.in_ready, 1'b0);
        check_eq("abort_wen", bus.mem_wen, 1'b0);
        check_eq("abort_ren", bus.mem_ren, 1'b0);
        check_eq("abort_flush", bus.mem_flush, 1'b0);
        check_eq("abort_out_valid", bus.out_valid, 1'b0);
        check_eq("abort_out_data", bus.out_data, 16'h0);
        check_eq("abort_done", done, 1'b0);
        bus.in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        return;
      end
      budget++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    start  = 1'b0;
    inject = 1'b0;
    check_eq("run_timeout", budget < BUDGET, 1'b1);
    check_eq("flush_cycles", flush_c, 1);
    check_eq("wen_total", wen_c, (it == 0) ? 0 : eff + it);
    check_eq("wen_only_fill", wenonly_c, (it == 0) ? 0 : eff);
    check_eq("ren_total", ren_c, it);
    check_eq("out_valid_total", outv_c, it);
    check_eq("exp_drained", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    check_eq("done_single", done_c, 1);
    check_eq("busy_end", busy, 1'b0);
    check_eq("err_end", err, exp_err);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    // Reset held with toggling inputs
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 16'($urandom);
      start        = i[0];
      cfg_depth    = DPW'($urandom);
      cfg_iter     = CW'($urandom);
      #1;
      check_eq("rst_in_ready", bus.in_ready, 1'b0);
      check_eq("rst_wen", bus.mem_wen, 1'b0);
      check_eq("rst_ren", bus.mem_ren, 1'b0);
      check_eq("rst_flush", bus.mem_flush, 1'b0);
      check_eq("rst_out_valid", bus.out_valid, 1'b0);
      check_eq("rst_out_data", bus.out_data, 16'h0);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_done", done, 1'b0);
      check_eq("rst_err", err, 1'b0);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);

    run(4, 6, 1'b0, 0, 1'b0);   // plain fill + rate-matched stream
    run(3, 4, 1'b1, 0, 1'b0);   // valid toggling 1010
    run(0, 2, 1'b0, 0, 1'b0);   // depth 0 behaves as depth 1
    run(5, 0, 1'b0, 0, 1'b0);   // zero iterations: flush then done
    run(8, 3, 1'b0, 1, 1'b1);   // stray core output + ignored start
    repeat (3) @(negedge clk);
    check_eq("err_sticky", err, 1'b1);
    run(4, 6, 1'b0, 2, 1'b0);   // abort mid-stream
    check_eq("err_cleared_by_reset", err, 1'b0);
    run(4, 6, 1'b0, 0, 1'b0);   // full run after abort

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "global timeout");
  end

endmodule
